// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-32 EX/MEM datapath: opcodes, R-type function
// codes, ALU operation codes and the decoded control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       regdst;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic [3:0] aluctl;
    } ctrl_t;

    // All-zero control word with the NOP ALU operation.
    localparam ctrl_t CTRL_NOP = '{regdst: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                   memtoreg: 1'b0, regwrite: 1'b0, alusrc: 1'b0,
                                   branch_eq: 1'b0, branch_ne: 1'b0, jump: 1'b0,
                                   aluctl: ALU_ADD};

    function automatic logic [31:0] sign_ext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/mips_dmem.sv
// Word-wide data memory: asynchronous clear, synchronous write, combinational
// read gated by the read enable.
module mips_dmem
    import mips_pkg::*;
#(
    parameter int NMEM = 32,
    parameter int AW   = $clog2(NMEM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [NMEM];

    // Storage array: cleared while reset is high, written on clock when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NMEM; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read port: reset forces zero so a cleared array is never observed stale.
    always_comb begin
        rdata = 32'h0000_0000;
        if (re && !rst) begin
            rdata = mem_r[addr];
        end else begin
            rdata = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/mips_ex_mem_datapath.sv
// EX/MEM core of the 5-stage MIPS-32 pipeline: main decoder, 32-bit ALU,
// branch decision and data memory with write-back selection.
module mips_ex_mem_datapath
    import mips_pkg::*;
#(
    parameter int NMEM = 32,
    localparam int AW  = $clog2(NMEM)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    output logic        regdst,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrc,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic        jump,
    output logic [3:0]  aluctl,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        branch_taken,
    output logic [31:0] rdata,
    output logic [31:0] wb_data
);

    ctrl_t       ctrl_s;
    logic [31:0] op_b_s;
    logic [31:0] alu_s;

    // Main decoder; R-type with an unsupported funct must not write back.
    always_comb begin
        ctrl_s = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                ctrl_s.regdst   = 1'b1;
                ctrl_s.regwrite = 1'b1;
                case (funct)
                    FN_ADD:  ctrl_s.aluctl = ALU_ADD;
                    FN_SUB:  ctrl_s.aluctl = ALU_SUB;
                    FN_AND:  ctrl_s.aluctl = ALU_AND;
                    FN_OR:   ctrl_s.aluctl = ALU_OR;
                    FN_NOR:  ctrl_s.aluctl = ALU_NOR;
                    FN_SLT:  ctrl_s.aluctl = ALU_SLT;
                    default: begin
                        ctrl_s.aluctl   = ALU_ADD;
                        ctrl_s.regwrite = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.memread  = 1'b1;
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.aluctl   = ALU_ADD;
            end
            OP_SW: begin
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.memwrite = 1'b1;
                ctrl_s.aluctl   = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_s.branch_eq = 1'b1;
                ctrl_s.aluctl    = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_s.branch_ne = 1'b1;
                ctrl_s.aluctl    = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.aluctl   = ALU_ADD;
            end
            OP_J: begin
                ctrl_s.jump = 1'b1;
            end
            default: begin
                ctrl_s = CTRL_NOP;
            end
        endcase
    end

    // Operand B select between register and sign-extended immediate.
    always_comb begin
        op_b_s = 32'h0000_0000;
        if (ctrl_s.alusrc) begin
            op_b_s = sign_ext16(imm);
        end else begin
            op_b_s = rt_data;
        end
    end

    // ALU; arithmetic wraps and SLT compares as signed two's complement.
    always_comb begin
        alu_s = 32'h0000_0000;
        case (ctrl_s.aluctl)
            ALU_AND: alu_s = rs_data & op_b_s;
            ALU_OR:  alu_s = rs_data | op_b_s;
            ALU_ADD: alu_s = rs_data + op_b_s;
            ALU_SUB: alu_s = rs_data - op_b_s;
            ALU_SLT: alu_s = ($signed(rs_data) < $signed(op_b_s)) ? 32'h0000_0001 : 32'h0000_0000;
            ALU_NOR: alu_s = ~(rs_data | op_b_s);
            default: alu_s = 32'h0000_0000;
        endcase
    end

    assign regdst    = ctrl_s.regdst;
    assign memread   = ctrl_s.memread;
    assign memwrite  = ctrl_s.memwrite;
    assign memtoreg  = ctrl_s.memtoreg;
    assign regwrite  = ctrl_s.regwrite;
    assign alusrc    = ctrl_s.alusrc;
    assign branch_eq = ctrl_s.branch_eq;
    assign branch_ne = ctrl_s.branch_ne;
    assign jump      = ctrl_s.jump;
    assign aluctl    = ctrl_s.aluctl;
    assign alu_out   = alu_s;
    assign zero      = (alu_s == 32'h0000_0000);
    assign branch_taken = (ctrl_s.branch_eq & zero) | (ctrl_s.branch_ne & ~zero);

    // Byte address bits [1:0] and everything above the word index are dropped.
    mips_dmem #(
        .NMEM (NMEM),
        .AW   (AW)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (ctrl_s.memwrite),
        .re    (ctrl_s.memread),
        .addr  (alu_s[AW+1:2]),
        .wdata (rt_data),
        .rdata (rdata)
    );

    // Write-back select between memory data and ALU result.
    always_comb begin
        wb_data = 32'h0000_0000;
        if (ctrl_s.memtoreg) begin
            wb_data = rdata;
        end else begin
            wb_data = alu_s;
        end
    end

endmodule

// File: tb/tb_mips_ex_mem_datapath.sv
// Self-checking bench: a vector table for the decoder/ALU through a scoreboard
// queue, followed by hand-written memory, wrap and reset sequences.
module tb_mips_ex_mem_datapath;

    localparam int NMEM = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        regdst, memread, memwrite, memtoreg, regwrite, alusrc;
    logic        branch_eq, branch_ne, jump, zero, branch_taken;
    logic [3:0]  aluctl;
    logic [31:0] alu_out, rdata, wb_data;

    int checks   = 0;
    int failures = 0;

    mips_ex_mem_datapath #(.NMEM(NMEM)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .regdst(regdst), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrc(alusrc),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump),
        .aluctl(aluctl), .alu_out(alu_out), .zero(zero),
        .branch_taken(branch_taken), .rdata(rdata), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // ctl order: regdst memread memwrite memtoreg regwrite alusrc beq bne jump
    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] im;
        logic [8:0]  ctl;
        logic [3:0]  actl;
        logic [31:0] alu;
        logic        z;
        logic        bt;
        logic [31:0] rd;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] im);
        opcode = op; funct = fn; rs_data = a; rt_data = b; imm = im;
    endtask

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                                input logic [8:0] ctl, input logic [3:0] actl, input logic [31:0] alu,
                                input logic z, input logic bt, input logic [31:0] rd,
                                input logic [31:0] wb);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn; v.a = a; v.b = b; v.im = im; v.ctl = ctl;
        v.actl = actl; v.alu = alu; v.z = z; v.bt = bt; v.rd = rd; v.wb = wb;
        return v;
    endfunction

    initial begin
        vec_t e;
        vecs.push_back(mk("radd",   6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 9'b100010000, 4'b0010, 32'd12, 1'b0, 1'b0, 32'd0, 32'd12));
        vecs.push_back(mk("slt",    6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 16'h0000, 9'b100010000, 4'b0111, 32'd1, 1'b0, 1'b0, 32'd0, 32'd1));
        vecs.push_back(mk("slt_sw", 6'h00, 6'h2A, 32'd1, 32'hFFFFFFFF, 16'h0000, 9'b100010000, 4'b0111, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0));
        vecs.push_back(mk("sub",    6'h00, 6'h22, 32'd5, 32'd7, 16'h0000, 9'b100010000, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFE));
        vecs.push_back(mk("and",    6'h00, 6'h24, 32'hF0F000FF, 32'h0FF00F0F, 16'h0000, 9'b100010000, 4'b0000, 32'h00F0000F, 1'b0, 1'b0, 32'd0, 32'h00F0000F));
        vecs.push_back(mk("or",     6'h00, 6'h25, 32'hF0F000FF, 32'h0FF00F0F, 16'h0000, 9'b100010000, 4'b0001, 32'hFFF00FFF, 1'b0, 1'b0, 32'd0, 32'hFFF00FFF));
        vecs.push_back(mk("nor",    6'h00, 6'h27, 32'hF0F000FF, 32'h0FF00F0F, 16'h0000, 9'b100010000, 4'b1100, 32'h000FF000, 1'b0, 1'b0, 32'd0, 32'h000FF000));
        vecs.push_back(mk("badfn",  6'h00, 6'h3F, 32'd1, 32'd2, 16'h0000, 9'b100000000, 4'b0010, 32'd3, 1'b0, 1'b0, 32'd0, 32'd3));
        vecs.push_back(mk("beq_t",  6'h04, 6'h00, 32'd3, 32'd3, 16'h0000, 9'b000000100, 4'b0110, 32'd0, 1'b1, 1'b1, 32'd0, 32'd0));
        vecs.push_back(mk("beq_n",  6'h04, 6'h00, 32'd3, 32'd4, 16'h0000, 9'b000000100, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFF));
        vecs.push_back(mk("bne_n",  6'h05, 6'h00, 32'd3, 32'd3, 16'h0000, 9'b000000010, 4'b0110, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0));
        vecs.push_back(mk("bne_t",  6'h05, 6'h00, 32'd3, 32'd4, 16'h0000, 9'b000000010, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, 32'hFFFFFFFF));
        vecs.push_back(mk("addi",   6'h08, 6'h00, 32'd10, 32'd77, 16'hFFFF, 9'b000011000, 4'b0010, 32'd9, 1'b0, 1'b0, 32'd0, 32'd9));
        vecs.push_back(mk("j",      6'h02, 6'h00, 32'd1, 32'd2, 16'h0000, 9'b000000001, 4'b0010, 32'd3, 1'b0, 1'b0, 32'd0, 32'd3));
        vecs.push_back(mk("badop",  6'h3F, 6'h20, 32'd10, 32'd20, 16'h1234, 9'b000000000, 4'b0010, 32'd30, 1'b0, 1'b0, 32'd0, 32'd30));
        vecs.push_back(mk("lw_ctl", 6'h23, 6'h00, 32'h100, 32'd5, 16'hFFFC, 9'b010111000, 4'b0010, 32'h000000FC, 1'b0, 1'b0, 32'd0, 32'd0));
        vecs.push_back(mk("sw_ctl", 6'h2B, 6'h00, 32'h10, 32'd0, 16'hFFF8, 9'b001001000, 4'b0010, 32'd8, 1'b0, 1'b0, 32'd0, 32'd8));

        // Reset state: memory reads 0 while rst is high, combinational logic live.
        rst = 1'b1;
        drive(6'h23, 6'h00, 32'd0, 32'd0, 16'd8);
        #2;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_alu_live", alu_out, 32'd8);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors through the scoreboard queue.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].im);
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            chk({e.name, "_ctl"}, {23'd0, regdst, memread, memwrite, memtoreg, regwrite,
                                  alusrc, branch_eq, branch_ne, jump}, {23'd0, e.ctl});
            chk({e.name, "_aluctl"}, {28'd0, aluctl}, {28'd0, e.actl});
            chk({e.name, "_alu"}, alu_out, e.alu);
            chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.z});
            chk({e.name, "_bt"}, {31'd0, branch_taken}, {31'd0, e.bt});
            chk({e.name, "_rdata"}, rdata, e.rd);
            chk({e.name, "_wb"}, wb_data, e.wb);
        end

        // Store two words, then load them back including address wrap.
        @(negedge clk);
        drive(6'h2B, 6'h00, 32'd0, 32'hDEADBEEF, 16'd8);
        @(negedge clk);
        drive(6'h2B, 6'h00, 32'd0, 32'h12345678, 16'd12);
        @(negedge clk);
        drive(6'h23, 6'h00, 32'd0, 32'd0, 16'd8);
        #1;
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_wb", wb_data, 32'hDEADBEEF);
        drive(6'h23, 6'h00, 32'd0, 32'd0, 16'(8 + 4 * NMEM));
        #1;
        chk("lw_wrap", rdata, 32'hDEADBEEF);
        drive(6'h23, 6'h00, 32'd0, 32'd0, 16'd12);
        #1;
        chk("lw_idx3", wb_data, 32'h12345678);
        drive(6'h23, 6'h00, 32'd0, 32'd0, 16'd11);
        #1;
        chk("lw_unaligned", rdata, 32'h00000000 + 32'hDEADBEEF);

        // Asynchronous reset pulse between clock edges clears memory.
        drive(6'h23, 6'h00, 32'd0, 32'd0, 16'd8);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_idx2", rdata, 32'd0);

        // Store attempted during reset must not land.
        @(negedge clk);
        rst = 1'b1;
        drive(6'h2B, 6'h00, 32'd0, 32'hAAAA5555, 16'd8);
        @(negedge clk);
        rst = 1'b0;
        drive(6'h23, 6'h00, 32'd0, 32'd0, 16'd8);
        #1;
        chk("sw_in_rst", rdata, 32'd0);

        // Fresh write after reset is visible right after the edge.
        @(negedge clk);
        drive(6'h2B, 6'h00, 32'd4, 32'hCAFEF00D, 16'd0);
        @(posedge clk);
        #1;
        drive(6'h23, 6'h00, 32'd4, 32'd0, 16'd0);
        #1;
        chk("post_rst_write", rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
